// File: rtl/cordiccart2pol_pkg.sv
// Shared helpers for the cordiccart2pol datapath: small integer helpers and the
// product post-processing (round, arithmetic shift, range reduction).
package cordiccart2pol_pkg;

    // Post-processing works on a fixed wide container; products up to 61 bits fit.
    localparam int MAXW = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Returns {ovf, value}; value is the full-width result, callers keep the low dw bits.
    function automatic logic [MAXW:0] round_shift_sat(
        input logic signed [MAXW-1:0] prod,
        input int                     shift,
        input logic                   rnd,
        input logic                   sat,
        input logic                   sgn,
        input int                     dw
    );
        logic signed [MAXW-1:0] one, v, hi, lo;
        logic                   of;
        one = MAXW'(1);
        v   = prod;
        if (rnd && shift > 0) v = v + (one <<< (shift - 1));
        v = v >>> shift;
        if (sgn) begin
            hi = (one <<< (dw - 1)) - one;
            lo = -(one <<< (dw - 1));
        end else begin
            hi = (one <<< dw) - one;
            lo = '0;
        end
        // Out of range is exactly "upper bits are not a pure extension" when wrapping.
        of = (v > hi) || (v < lo);
        if (sat && v > hi)      v = hi;
        else if (sat && v < lo) v = lo;
        return {of, v};
    endfunction

endpackage

// File: rtl/cordiccart2pol_pipe_stage.sv
// One elastic pipeline slot: valid bit plus payload, advancing when enabled.
module cordiccart2pol_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             en,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);

    // Payload only moves with a valid item so empty slots keep stale data.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (en) begin
            vout <= vin;
            if (vin) dout <= din;
        end
    end

endmodule

// File: rtl/cordiccart2pol_mul_pipe.sv
// Elastic pipelined multiplier with per-operand signedness, optional
// round/shift and saturation; NUM_STAGE slots with bubble-collapsing enables.
module cordiccart2pol_mul_pipe
    import cordiccart2pol_pkg::*;
#(
    parameter int DIN0_WIDTH  = 18,
    parameter int DIN1_WIDTH  = 20,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int DOUT_WIDTH  = 37,
    parameter int SHIFT       = 0,
    parameter int ROUND       = 0,
    parameter int SAT         = 0,
    parameter int NUM_STAGE   = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int P          = DIN0_WIDTH + DIN1_WIDTH;
    localparam int RW         = DOUT_WIDTH + 1;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    // Operands are widened to P+2 so the product is exact before post-processing.
    function automatic logic [RW-1:0] mul_post(input logic [DIN0_WIDTH-1:0] a,
                                               input logic [DIN1_WIDTH-1:0] b);
        logic                   e0, e1;
        logic signed [P+1:0]    ax, bx, pr;
        logic signed [MAXW-1:0] pw;
        logic [MAXW:0]          r;
        e0 = (DIN0_SIGNED != 0) ? a[DIN0_WIDTH-1] : 1'b0;
        e1 = (DIN1_SIGNED != 0) ? b[DIN1_WIDTH-1] : 1'b0;
        ax = {{(DIN1_WIDTH+2){e0}}, a};
        bx = {{(DIN0_WIDTH+2){e1}}, b};
        pr = ax * bx;
        pw = {{(MAXW-P-2){pr[P+1]}}, pr};
        r  = round_shift_sat(pw, SHIFT, ROUND != 0, SAT != 0, RES_SIGNED, DOUT_WIDTH);
        return {r[MAXW], r[DOUT_WIDTH-1:0]};
    endfunction

    generate
        if (NUM_STAGE == 0) begin : g_comb
            logic [RW-1:0] r;
            assign r         = mul_post(din0, din1);
            assign dout      = r[DOUT_WIDTH-1:0];
            assign ovf       = r[DOUT_WIDTH];
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
        end else begin : g_pipe
            // With two or more stages the first slot holds raw operands.
            localparam int OFF = (NUM_STAGE > 1) ? 1 : 0;
            localparam int R   = NUM_STAGE - OFF;

            logic [NUM_STAGE:0]   v;
            logic [NUM_STAGE+1:0] en;
            logic [R:0][RW-1:0]   rpl;

            assign v[0]            = in_valid;
            assign en[NUM_STAGE+1] = out_ready;
            assign in_ready        = en[1];

            for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_en
                assign en[k] = !v[k] || en[k+1];
            end

            if (OFF == 1) begin : g_ops
                logic [P-1:0] ops;
                cordiccart2pol_pipe_stage #(.WIDTH(P)) u_ops (
                    .ap_clk (ap_clk),
                    .ap_rst (ap_rst),
                    .en     (en[1]),
                    .vin    (v[0]),
                    .din    ({din0, din1}),
                    .vout   (v[1]),
                    .dout   (ops)
                );
                assign rpl[0] = mul_post(ops[P-1:DIN1_WIDTH], ops[DIN1_WIDTH-1:0]);
            end else begin : g_noops
                assign rpl[0] = mul_post(din0, din1);
            end

            for (genvar j = 1; j <= R; j++) begin : g_res
                cordiccart2pol_pipe_stage #(.WIDTH(RW)) u_st (
                    .ap_clk (ap_clk),
                    .ap_rst (ap_rst),
                    .en     (en[j+OFF]),
                    .vin    (v[j+OFF-1]),
                    .din    (rpl[j-1]),
                    .vout   (v[j+OFF]),
                    .dout   (rpl[j])
                );
            end

            assign out_valid = v[NUM_STAGE];
            assign dout      = rpl[R][DOUT_WIDTH-1:0];
            assign ovf       = rpl[R][DOUT_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_cordiccart2pol_mul_pipe.sv
// Bench for cordiccart2pol_mul_pipe: four parameterisations share one input bus,
// results are checked against a plain-integer reference model.
module tb_cordiccart2pol_mul_pipe;

    localparam int DW = 37;

    logic          ap_clk    = 1'b0;
    logic          ap_rst    = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [17:0]   din0      = '0;
    logic [19:0]   din1      = '0;

    logic          in_ready_a, out_valid_a, ovf_a;
    logic          in_ready_s, out_valid_s, ovf_s;
    logic          in_ready_r, out_valid_r, ovf_r;
    logic          in_ready_c, out_valid_c, ovf_c;
    logic [DW-1:0] dout_a, dout_s, dout_r, dout_c;

    always #5 ap_clk = ~ap_clk;

    cordiccart2pol_mul_pipe dut_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .din0(din0), .din1(din1), .out_valid(out_valid_a), .out_ready(out_ready),
        .dout(dout_a), .ovf(ovf_a));

    cordiccart2pol_mul_pipe #(.SAT(1)) dut_s (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .din0(din0), .din1(din1), .out_valid(out_valid_s), .out_ready(out_ready),
        .dout(dout_s), .ovf(ovf_s));

    cordiccart2pol_mul_pipe #(.DIN0_SIGNED(1), .SHIFT(4), .ROUND(1)) dut_r (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .din0(din0), .din1(din1), .out_valid(out_valid_r), .out_ready(out_ready),
        .dout(dout_r), .ovf(ovf_r));

    cordiccart2pol_mul_pipe #(.NUM_STAGE(0)) dut_c (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .din0(din0), .din1(din1), .out_valid(out_valid_c), .out_ready(out_ready),
        .dout(dout_c), .ovf(ovf_c));

    typedef struct packed { logic o; logic [DW-1:0] d; } res_t;
    typedef struct packed { res_t a; res_t s; res_t r; } trip_t;

    trip_t exp_q[$];
    trip_t got_q[$];
    int    acc_cyc[$];
    int    emit_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    function automatic longint prod(input logic [17:0] a, input logic [19:0] b,
                                    input bit sa, input bit sb);
        longint x, y;
        x = sa ? longint'($signed(a)) : longint'(a);
        y = sb ? longint'($signed(b)) : longint'(b);
        return x * y;
    endfunction

    function automatic res_t post(input longint p, input int sh, input bit rnd,
                                  input bit sat, input bit sgn);
        longint v, hi, lo, ext;
        res_t   r;
        v = p;
        if (rnd && sh > 0) v = v + (longint'(1) << (sh - 1));
        v  = v >>> sh;
        hi = sgn ? (longint'(1) << (DW - 1)) - 1 : (longint'(1) << DW) - 1;
        lo = sgn ? -(longint'(1) << (DW - 1)) : 64'sd0;
        if (sat) begin
            r.o = (v > hi) || (v < lo);
            r.d = DW'((v > hi) ? hi : ((v < lo) ? lo : v));
        end else begin
            r.d = DW'(v);
            ext = sgn ? longint'($signed(r.d)) : longint'(r.d);
            r.o = (ext != v);
        end
        return r;
    endfunction

    function automatic trip_t model(input logic [17:0] a, input logic [19:0] b);
        trip_t t;
        t.a = post(prod(a, b, 1'b0, 1'b1), 0, 1'b0, 1'b0, 1'b1);
        t.s = post(prod(a, b, 1'b0, 1'b1), 0, 1'b0, 1'b1, 1'b1);
        t.r = post(prod(a, b, 1'b1, 1'b1), 4, 1'b1, 1'b0, 1'b1);
        return t;
    endfunction

    // Advances one cycle, logging handshakes seen away from the clock edge.
    task automatic tick(output bit acc);
        trip_t g;
        @(negedge ap_clk);
        acc = 1'b0;
        if (ap_rst) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (in_valid && in_ready_a) begin
                acc = 1'b1;
                exp_q.push_back(model(din0, din1));
                acc_cyc.push_back(cyc);
            end
            if (out_valid_a && out_ready) begin
                g.a.o = ovf_a; g.a.d = dout_a;
                g.s.o = ovf_s; g.s.d = dout_s;
                g.r.o = ovf_r; g.r.d = dout_r;
                got_q.push_back(g);
                emit_cyc.push_back(cyc);
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); emit_cyc.delete();
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick(acc);
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (out_valid_a !== 1'b0 || dout_a !== '0 || ovf_a !== 1'b0 || dout_s !== '0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b dout=%h ovf=%b dout_s=%h exp 0 0 0 0",
                     out_valid_a, dout_a, ovf_a, dout_s);
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready_a);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_latency();
        bit acc;
        clear_logs();
        din0 = 18'd3; din1 = 20'hFFFFB; in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got_q.size() == 0; k++) tick(acc);
        checks++;
        if (got_q.size() != 1 || acc_cyc.size() != 1) begin
            errors++;
            $display("FAIL latency_count got %0d results exp 1", got_q.size());
        end else begin
            checks++;
            if (emit_cyc[0] - acc_cyc[0] != 3) begin
                errors++;
                $display("FAIL latency got %0d exp 3", emit_cyc[0] - acc_cyc[0]);
            end
            checks++;
            if (got_q[0].a.d !== 37'h1F_FFFF_FFF1 || got_q[0].a.o !== 1'b0) begin
                errors++;
                $display("FAIL mul_3x-5 got %h ovf %b exp 1ffffffff1 ovf 0",
                         got_q[0].a.d, got_q[0].a.o);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bit acc;
        int nacc;
        clear_logs();
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            din0 = 18'($urandom); din1 = 20'($urandom); in_valid = 1'b1;
            tick(acc);
            if (acc) nacc++;
        end
        drain();
        checks++;
        if (nacc != 16 || got_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_count accepts %0d results %0d exp 16 16", nacc, got_q.size());
        end else begin
            checks++;
            if (emit_cyc[15] - emit_cyc[0] != 15) begin
                errors++;
                $display("FAIL b2b_throughput span %0d exp 15", emit_cyc[15] - emit_cyc[0]);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_corners();
        bit acc;
        logic [17:0] a_t[5] = '{18'h3FFFF, 18'd6, 18'h3FFFA, 18'd7, 18'd8};
        logic [19:0] b_t[5] = '{20'h80000, 20'd4, 20'd4, 20'd1, 20'd1};
        logic [DW-1:0] r_t[5] = '{37'h0, 37'd2, 37'h1F_FFFF_FFFF, 37'd0, 37'd1};
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            din0 = a_t[i]; din1 = b_t[i]; in_valid = 1'b1;
            tick(acc);
        end
        drain();
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL corner_count got %0d exp 5", got_q.size());
        end else begin
            checks++;
            if (got_q[0].a.d !== 37'h00_0008_0000 || got_q[0].a.o !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ovf got %h ovf %b exp 0000080000 ovf 1",
                         got_q[0].a.d, got_q[0].a.o);
            end
            checks++;
            if (got_q[0].s.d !== 37'h10_0000_0000 || got_q[0].s.o !== 1'b1) begin
                errors++;
                $display("FAIL sat_min got %h ovf %b exp 1000000000 ovf 1",
                         got_q[0].s.d, got_q[0].s.o);
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (got_q[i].r.d !== r_t[i] || got_q[i].r.o !== 1'b0) begin
                    errors++;
                    $display("FAIL round[%0d] got %h ovf %b exp %h ovf 0",
                             i, got_q[i].r.d, got_q[i].r.o, r_t[i]);
                end
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL corner_model[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit          acc;
        bit          held;
        int          i;
        logic [DW-1:0] hold;
        logic [17:0] a_t[8];
        logic [19:0] b_t[8];
        clear_logs();
        for (int k = 0; k < 8; k++) begin a_t[k] = 18'($urandom); b_t[k] = 20'($urandom); end
        i = 0; held = 1'b0; hold = '0;
        for (int t = 0; t < 60 && (i < 8 || t < 6); t++) begin
            out_ready = (t >= 5);
            in_valid  = (i < 8);
            din0 = a_t[i % 8]; din1 = b_t[i % 8];
            tick(acc);
            if (acc) i++;
            if (t < 5 && out_valid_a) begin
                if (!held) begin
                    hold = dout_a; held = 1'b1;
                end else begin
                    checks++;
                    if (dout_a !== hold) begin
                        errors++;
                        $display("FAIL stall_stable t=%0d got %h exp %h", t, dout_a, hold);
                    end
                end
            end
            if (t == 4) begin
                checks++;
                if (i != 3 || in_ready_a !== 1'b0 || in_ready_r !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_capacity accepts %0d in_ready %b exp 3 0", i, in_ready_a);
                end
                checks++;
                if (out_valid_s !== out_valid_a || out_valid_r !== out_valid_a || out_valid_a !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid got %b%b%b exp 111", out_valid_a, out_valid_s, out_valid_r);
                end
            end
        end
        drain();
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL stall_count got %0d exp 8", got_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL stall_order[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_bubble();
        bit acc;
        int nacc;
        clear_logs();
        out_ready = 1'b0;
        din0 = 18'($urandom); din1 = 20'($urandom); in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        repeat (3) tick(acc);
        checks++;
        if (out_valid_a !== 1'b1 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL bubble_open out_valid %b in_ready %b exp 1 1", out_valid_a, in_ready_a);
        end
        nacc = 0;
        for (int k = 0; k < 4; k++) begin
            din0 = 18'($urandom); din1 = 20'($urandom); in_valid = 1'b1;
            tick(acc);
            if (acc) nacc++;
        end
        checks++;
        if (nacc != 2 || in_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL bubble_fill accepts %0d in_ready %b exp 2 0", nacc, in_ready_a);
        end
        drain();
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL bubble_count got %0d exp 3", got_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL bubble_order[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        clear_logs();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din0 = 18'($urandom_range(1, 1000)); din1 = 20'($urandom_range(1, 1000)); in_valid = 1'b1;
            tick(acc);
        end
        in_valid = 1'b0;
        ap_rst   = 1'b1;
        tick(acc);
        checks++;
        if (out_valid_a !== 1'b0 || dout_a !== '0 || ovf_a !== 1'b0 || in_ready_a !== 1'b1 ||
            dout_r !== '0) begin
            errors++;
            $display("FAIL reset_mid out_valid %b dout %h ovf %b in_ready %b exp 0 0 0 1",
                     out_valid_a, dout_a, ovf_a, in_ready_a);
        end
        ap_rst = 1'b0;
        repeat (8) tick(acc);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_stale got %0d results exp 0", got_q.size());
        end
    endtask

    task automatic test_comb();
        trip_t t;
        for (int k = 0; k < 20; k++) begin
            din0 = (k == 0) ? 18'h3FFFF : 18'($urandom);
            din1 = (k == 0) ? 20'h80000 : 20'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            t = model(din0, din1);
            checks++;
            if (dout_c !== t.a.d || ovf_c !== t.a.o || out_valid_c !== in_valid ||
                in_ready_c !== out_ready) begin
                errors++;
                $display("FAIL comb[%0d] got %h/%b v%b r%b exp %h/%b v%b r%b", k, dout_c, ovf_c,
                         out_valid_c, in_ready_c, t.a.d, t.a.o, in_valid, out_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_corners();
        test_stall();
        test_bubble();
        test_reset_mid();
        test_comb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
